// File: rtl/filter_pkg.sv
// Shared types and defaults for the filter mode scheduler: mode encoding,
// BPM clamp limits and small helpers used by the scheduler top.
package filter_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_MULT = 2'd2
  } mode_state_t;

  localparam int BPM_MIN_DEF   = 40;
  localparam int BPM_MAX_DEF   = 200;
  localparam int BPM_RESET_DEF = 120;

  function automatic logic [7:0] clamp_bpm(input logic [7:0] value,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    if (value < lo)      return lo;
    else if (value > hi) return hi;
    else                 return value;
  endfunction

  // The unreachable encoding 3 behaves like OFF, so it also advances to ADD.
  function automatic mode_state_t next_mode(input mode_state_t cur);
    case (cur)
      MODE_OFF:  return MODE_ADD;
      MODE_ADD:  return MODE_MULT;
      MODE_MULT: return MODE_OFF;
      default:   return MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises a raw active-low pushbutton and debounces it; emits a single
// registered pulse for each debounced press (high-to-low transition).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Any cycle where the synchronised input agrees with the accepted level
      // restarts the count, so bounces never accumulate.
      if (sync_2 != level) begin
        if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_2;
          count <= '0;
          press <= ~sync_2;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/filter_mode_scheduler.sv
// Collects mode-button presses and BPM estimates during a frame and applies
// them to the pixel filter controls only at the next frame boundary.
module filter_mode_scheduler
  import filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BPM_MIN         = BPM_MIN_DEF,
  parameter int BPM_MAX         = BPM_MAX_DEF,
  parameter int BPM_RESET       = BPM_RESET_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       key_mode_n,
  input  logic [7:0] bpm_in,
  input  logic       bpm_valid,
  output logic       filter_enable,
  output logic       filter_mode,
  output logic [7:0] bpm_out,
  output logic       frame_tick,
  output logic [1:0] mode_state
);

  logic        press;
  logic        frame_hit;
  logic        enable_next;
  logic        mode_next;
  logic [7:0]  pending_bpm;
  mode_state_t pending_mode;
  mode_state_t pending_mode_next;
  mode_state_t applied_mode;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk   (clk),
    .reset (reset),
    .key_n (key_mode_n),
    .press (press)
  );

  assign frame_hit  = (hcount == 10'd0) && (vcount == 10'd0);
  assign mode_state = applied_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_mode <= MODE_OFF;
    else       pending_mode <= pending_mode_next;
  end

  always_comb begin
    pending_mode_next = pending_mode;
    enable_next       = 1'b0;
    mode_next         = 1'b1;
    if (press) pending_mode_next = next_mode(pending_mode);
    case (pending_mode)
      MODE_ADD: begin
        enable_next = 1'b1;
        mode_next   = 1'b1;
      end
      MODE_MULT: begin
        enable_next = 1'b1;
        mode_next   = 1'b0;
      end
      default: begin
        enable_next = 1'b0;
        mode_next   = 1'b1;
      end
    endcase
  end

  // bpm_valid qualifies bpm_in for exactly the cycle it is high; there is no
  // ready, every qualified sample is taken and the last one in a frame wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick    <= 1'b0;
      pending_bpm   <= 8'(BPM_RESET);
      applied_mode  <= MODE_OFF;
      bpm_out       <= 8'(BPM_RESET);
      filter_enable <= 1'b0;
      filter_mode   <= 1'b1;
    end else begin
      frame_tick <= frame_hit;
      if (bpm_valid) pending_bpm <= clamp_bpm(bpm_in, 8'(BPM_MIN), 8'(BPM_MAX));
      // Applied values sample the pending registers before this edge's
      // press/bpm updates land, so coincident changes wait one frame.
      if (frame_tick) begin
        applied_mode  <= pending_mode;
        bpm_out       <= pending_bpm;
        filter_enable <= enable_next;
        filter_mode   <= mode_next;
      end
    end
  end

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Bench for filter_mode_scheduler with a short debounce and a 32x8 frame;
// expected outputs come from a frame-level model of pending/applied values.
module tb_filter_mode_scheduler;

  localparam int H_TOTAL = 32;
  localparam int V_TOTAL = 8;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic       clk;
  logic       reset;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       key_mode_n;
  logic [7:0] bpm_in;
  logic       bpm_valid;
  logic       filter_enable;
  logic       filter_mode;
  logic [7:0] bpm_out;
  logic       frame_tick;
  logic [1:0] mode_state;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  // Reference model: pending and applied values at frame granularity.
  int m_pend, m_app, b_pend, b_app;
  logic [11:0] cur_exp;
  logic [11:0] exp_q[$];

  filter_mode_scheduler #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hcount        (hcount),
    .vcount        (vcount),
    .key_mode_n    (key_mode_n),
    .bpm_in        (bpm_in),
    .bpm_valid     (bpm_valid),
    .filter_enable (filter_enable),
    .filter_mode   (filter_mode),
    .bpm_out       (bpm_out),
    .frame_tick    (frame_tick),
    .mode_state    (mode_state)
  );

  // Clock, reset and raster counters
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    hcount = '0;
    vcount = '0;
    forever begin
      @(posedge clk);
      #1;
      pos    = (pos + 1) % FRAME;
      hcount = 10'(pos % H_TOTAL);
      vcount = 10'(pos / H_TOTAL);
    end
  end

  // Model helpers
  function automatic logic [11:0] exp_pack(input int m, input int b);
    logic en, md;
    en = (m == 1) || (m == 2);
    md = (m != 2);
    return {en, md, 2'(m), 8'(b)};
  endfunction

  function automatic logic [11:0] obs();
    return {filter_enable, filter_mode, mode_state, bpm_out};
  endfunction

  task automatic model_reset();
    m_pend = 0; m_app = 0; b_pend = 120; b_app = 120;
    cur_exp = exp_pack(0, 120);
    exp_q.delete();
  endtask

  task automatic model_press();
    m_pend = (m_pend + 1) % 3;
  endtask

  task automatic model_bpm(input int v);
    if (v < 40)       b_pend = 40;
    else if (v > 200) b_pend = 200;
    else              b_pend = v;
  endtask

  task automatic model_frame();
    m_app = m_pend;
    b_app = b_pend;
    cur_exp = exp_pack(m_app, b_app);
    exp_q.push_back(cur_exp);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic align(input int p);
    for (int i = 0; i <= FRAME; i++) begin
      step();
      if (pos == p) break;
    end
  endtask

  task automatic press_key(input int low_cycles, input int high_cycles);
    key_mode_n = 1'b0;
    repeat (low_cycles) step();
    key_mode_n = 1'b1;
    repeat (high_cycles) step();
  endtask

  task automatic drive_bpm(input int v);
    bpm_in    = 8'(v);
    bpm_valid = 1'b1;
    step();
    bpm_valid = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    bit seen;
    logic [11:0] e;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== cur_exp) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", obs(), cur_exp);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick);
    end
    align(100);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      checks++;
      if (obs() !== cur_exp) begin
        errors++; $display("FAIL reset_pre_frame got=%h exp=%h", obs(), cur_exp);
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_tick_timeout got=0 exp=1");
    end
    model_frame();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_first_frame got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_clean_press();
    bit seen;
    logic [11:0] e;
    align(4);
    press_key(10, 10);
    model_press();
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== cur_exp) begin
        errors++; $display("FAIL press_hold got=%h exp=%h", obs(), cur_exp);
      end
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL press_tick_timeout got=0 exp=1");
    end
    model_frame();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL press_apply got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_bounce();
    bit ok;
    logic [11:0] e;
    align(4);
    for (int i = 0; i < 4; i++) begin
      key_mode_n = (i % 2 == 1);
      repeat (2) step();
    end
    press_key(10, 10);
    model_press();
    wait_tick(ok);
    checks++;
    if (!ok || obs() !== cur_exp) begin
      errors++; $display("FAIL bounce_hold got=%h exp=%h tick=%0d", obs(), cur_exp, ok);
    end
    model_frame();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL bounce_apply got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_multi_press();
    bit ok;
    int n;
    logic [11:0] e;
    for (int f = 0; f < 6; f++) begin
      align(4);
      n = (f == 0) ? 3 : (f == 1) ? 2 : int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) begin
        press_key(int'($urandom_range(6, 12)), int'($urandom_range(8, 12)));
        model_press();
      end
      if (f >= 2 && $urandom_range(0, 1) == 1) begin
        n = int'($urandom_range(0, 255));
        drive_bpm(n);
        model_bpm(n);
      end
      wait_tick(ok);
      checks++;
      if (!ok || obs() !== cur_exp) begin
        errors++; $display("FAIL multi_hold f=%0d got=%h exp=%h tick=%0d", f, obs(), cur_exp, ok);
      end
      model_frame();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL multi_apply f=%0d got=%h exp=%h", f, obs(), e);
      end
    end
  endtask

  task automatic test_bpm_clamp();
    bit ok;
    int v;
    int cnt;
    logic [11:0] e;
    for (int f = 0; f < 7; f++) begin
      align(4);
      case (f)
        0: begin
          drive_bpm(20);  model_bpm(20);
          repeat (3) step();
          drive_bpm(250); model_bpm(250);
          drive_bpm(90);  model_bpm(90);
        end
        1: begin drive_bpm(20);  model_bpm(20);  end
        2: begin drive_bpm(250); model_bpm(250); end
        default: begin
          cnt = int'($urandom_range(1, 4));
          for (int k = 0; k < cnt; k++) begin
            v = int'($urandom_range(0, 255));
            drive_bpm(v);
            model_bpm(v);
            repeat ($urandom_range(0, 5)) step();
          end
        end
      endcase
      wait_tick(ok);
      checks++;
      if (!ok || obs() !== cur_exp) begin
        errors++; $display("FAIL bpm_hold f=%0d got=%h exp=%h tick=%0d", f, obs(), cur_exp, ok);
      end
      model_frame();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL bpm_apply f=%0d got=%h exp=%h", f, obs(), e);
      end
    end
  endtask

  task automatic test_coincident();
    bit ok;
    logic [11:0] e;
    align(4);
    press_key(10, 10);
    model_press();
    drive_bpm(77);
    model_bpm(77);
    // Key falls five cycles before the raster wraps so its press event
    // lands on the frame_tick cycle; bpm_valid is driven in that same cycle.
    align(FRAME - 5);
    key_mode_n = 1'b0;
    repeat (6) step();
    bpm_in    = 8'd150;
    bpm_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++; $display("FAIL coinc_tick_align got=%b exp=1", frame_tick);
    end
    model_frame();
    model_press();
    model_bpm(150);
    step();
    bpm_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL coinc_old_apply got=%h exp=%h", obs(), e);
    end
    repeat (2) step();
    key_mode_n = 1'b1;
    repeat (10) step();
    wait_tick(ok);
    checks++;
    if (!ok || obs() !== cur_exp) begin
      errors++; $display("FAIL coinc_hold got=%h exp=%h tick=%0d", obs(), cur_exp, ok);
    end
    model_frame();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL coinc_new_apply got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [11:0] e;
    align(4);
    press_key(10, 10);
    drive_bpm(180);
    key_mode_n = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs() !== cur_exp || frame_tick !== 1'b0) begin
      errors++; $display("FAIL midreset_async got=%h tick=%b exp=%h tick=0", obs(), frame_tick, cur_exp);
    end
    key_mode_n = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    wait_tick(ok);
    checks++;
    if (!ok || obs() !== cur_exp) begin
      errors++; $display("FAIL midreset_hold got=%h exp=%h tick=%0d", obs(), cur_exp, ok);
    end
    model_frame();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL midreset_apply got=%h exp=%h", obs(), e);
    end
  endtask

  initial begin
    reset      = 1'b1;
    key_mode_n = 1'b1;
    bpm_in     = '0;
    bpm_valid  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_press();
    test_bpm_clamp();
    test_coincident();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_mode_scheduler.md
FILTER_MODE_SCHEDULER -- requirements
Module: filter_mode_scheduler

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning stable-input cycles required to accept a button change (10 ms at 25 MHz).
REQ-002 SHALL have parameter BPM_MIN, default 40, meaning the lower clamp for the applied BPM.
REQ-003 SHALL have parameter BPM_MAX, default 200, meaning the upper clamp for the applied BPM.
REQ-004 SHALL have parameter BPM_RESET, default 120, meaning the BPM applied out of reset.
REQ-005 SHALL have port clk, input, 1 bit: pixel clock; the block uses one clock only.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port hcount, input, 10 bits: horizontal pixel counter from the sync generator.
REQ-008 SHALL have port vcount, input, 10 bits: vertical line counter from the sync generator.
REQ-009 SHALL have port key_mode_n, input, 1 bit: raw, asynchronous, active-low mode pushbutton.
REQ-010 SHALL have port bpm_in, input, 8 bits: BPM estimate from upstream.
REQ-011 SHALL have port bpm_valid, input, 1 bit: single-cycle qualifier for bpm_in.
REQ-012 SHALL have port filter_enable, output, 1 bit: enable to the pixel-wise filter.
REQ-013 SHALL have port filter_mode, output, 1 bit: filter mode (1 = additive, 0 = multiplicative).
REQ-014 SHALL have port bpm_out, output, 8 bits: BPM value applied to the filter.
REQ-015 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-016 SHALL have port mode_state, output, 2 bits: the currently applied mode state, for debug.

Function
REQ-017 SHALL pass key_mode_n through a 2-flop synchroniser before any other use.
REQ-018 SHALL update the debounced key level only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-019 SHALL generate exactly one press event per debounced high-to-low transition; releases SHALL generate no event.
REQ-020 SHALL implement mode states OFF=0, ADD=1, MULT=2; each press event SHALL advance pending_mode OFF->ADD->MULT->OFF; value 3 SHALL be unreachable and SHALL decode to OFF.
REQ-021 SHALL register a frame boundary when hcount==0 && vcount==0, and SHALL assert frame_tick on the cycle following that condition.
REQ-022 SHALL, on the frame_tick cycle, copy pending_mode into applied_mode and pending_bpm into bpm_out; applied values SHALL change at no other time.
REQ-023 SHALL decode outputs from applied_mode: OFF -> enable 0, mode 1; ADD -> enable 1, mode 1; MULT -> enable 1, mode 0.
REQ-024 SHALL, on bpm_valid, load pending_bpm with bpm_in clamped to [BPM_MIN, BPM_MAX]; multiple bpm_valid pulses within one frame SHALL leave the last value.
REQ-025 SHALL give precedence to the frame boundary when a press event and frame_tick coincide: the old pending_mode is applied, and the press advances pending_mode for the next frame.
REQ-026 SHALL likewise, when bpm_valid and frame_tick coincide, apply the old pending_bpm and hold the new value pending.
REQ-027 SHALL accumulate multiple presses within one frame; for example, two presses from OFF SHALL apply MULT at the next boundary.
REQ-028 SHALL have a latency of 1 cycle from frame_tick to updated outputs, all of which are registered.

Reset
REQ-029 SHALL, on reset assertion, immediately drive filter_enable=0, filter_mode=1, bpm_out=BPM_RESET, frame_tick=0, mode_state=OFF.
REQ-030 SHALL, on reset, clear pending_mode to OFF, set pending_bpm to BPM_RESET, and set the debounced level to 1 (released) with the counter at 0.
REQ-031 SHALL discard any in-progress debounce or pending change when reset is asserted mid-frame.
REQ-032 SHALL apply no change until the first frame boundary after reset deasserts.

Structure
REQ-033 SHALL place mode_state_t (OFF/ADD/MULT) and the BPM_MIN/BPM_MAX/BPM_RESET defaults in the shared package filter_pkg.
REQ-034 SHALL implement the synchroniser and debounce counter as the single sub-module key_debouncer (parameter DEBOUNCE_CYCLES), whose output is a press pulse.
REQ-035 SHALL keep the mode FSM, BPM clamp and frame latch in the top of filter_mode_scheduler.

Verification (bench with DEBOUNCE_CYCLES=4 and a reduced-size frame)
REQ-036 SHALL cover: reset held, then released -> enable=0, mode=1, bpm_out=120, and no change before the first frame_tick.
REQ-037 SHALL cover: a clean 10-cycle press mid-frame -> outputs unchanged until frame_tick, then enable=1, mode=1, mode_state=1.
REQ-038 SHALL cover: a press bouncing 1-0-1-0 at 2-cycle intervals, then a stable low -> exactly one press event.
REQ-039 SHALL cover: three presses in one frame from OFF -> OFF re-applied; two presses -> MULT (enable=1, mode=0).
REQ-040 SHALL cover: bpm_in=20, then 250, then 90 within one frame -> bpm_out=90 at the boundary; 20 alone -> 40; 250 alone -> 200.
REQ-041 SHALL cover: a press event and bpm_valid(150) coincident with frame_tick -> old values applied, new values applied at the following frame_tick.
